// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
//   Bus between the fetch/decode/execute sequencer and the datapath.
//   master: sequencer side. It drives the ROM address and all decode strobes,
//           and receives the ROM data.
//   slave : datapath/memory side.
//   Signals:
//     rom_addr/rom_q    program ROM address and data
//     reg_addr/reg_we/reg_sel/imm   regfile port
//     alu_op/acc_we     ULA control
//     dram_addr/dram_we data RAM control
//     led_we/seg_we     display latches
//     pc/state/instr_done/illegal  status
interface cpu_sequencer_if;
    logic [7:0]  rom_addr;
    logic [15:0] rom_q;
    logic [3:0]  reg_addr;
    logic        reg_we;
    logic [1:0]  reg_sel;
    logic [7:0]  imm;
    logic [3:0]  alu_op;
    logic        acc_we;
    logic [7:0]  dram_addr;
    logic        dram_we;
    logic        led_we;
    logic        seg_we;
    logic [7:0]  pc;
    logic [2:0]  state;
    logic        instr_done;
    logic        illegal;

    modport master (
        output rom_addr, reg_addr, reg_we, reg_sel, imm, alu_op, acc_we,
               dram_addr, dram_we, led_we, seg_we, pc, state, instr_done, illegal,
        input  rom_q
    );

    modport slave (
        input  rom_addr, reg_addr, reg_we, reg_sel, imm, alu_op, acc_we,
               dram_addr, dram_we, led_we, seg_we, pc, state, instr_done, illegal,
        output rom_q
    );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Multi-cycle fetch/decode/execute controller for the 16-bit processor.
//   It owns the PC and the instruction register, and it decodes IR into the
//   regfile, ULA, data RAM and display strobes. Free-run (run=1) and
//   single-step (a rising edge on step) modes are supported.
//   Instruction format: [15:12] opcode, [11:8] rd, [7:0] imm/address.
// Ports
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset
//   run   1 = free-run, 0 = single-step
//   step  step request level; its rising edge starts one instruction from IDLE
//   bus   cpu_sequencer_if.master (ROM address/data, strobes, status)
// Parameters
//   ROM_LAT   program ROM read latency, 1..4 cycles (length of FETCH)
//   DRAM_LAT  data RAM read latency, 1..4 cycles (length of MEM)
module cpu_sequencer #(
    parameter int unsigned ROM_LAT  = 1,
    parameter int unsigned DRAM_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    cpu_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,  OP_LI   = 4'd1,  OP_LOAD = 4'd2,  OP_STORE = 4'd3,
        OP_ADD  = 4'd4,  OP_SUB  = 4'd5,  OP_AND  = 4'd6,  OP_OR    = 4'd7,
        OP_XOR  = 4'd8,  OP_NOT  = 4'd9,  OP_LIN  = 4'd10, OP_PRINT = 4'd11,
        OP_SEG  = 4'd12, OP_JMP  = 4'd13, OP_ILL0 = 4'd14, OP_ILL1  = 4'd15
    } opcode_e;

    state_e      state_q, state_n;
    logic [1:0]  cnt_q, cnt_n;
    logic [7:0]  pc_q;
    logic [15:0] ir_q;
    logic        illegal_q;
    logic        step_q;
    logic        step_rise;
    logic        last;
    logic        set_illegal;
    opcode_e     opcode;

    logic        reg_we, acc_we, dram_we, led_we, seg_we;
    logic [1:0]  reg_sel;

    assign opcode    = opcode_e'(ir_q[15:12]);
    assign step_rise = step & ~step_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            step_q  <= step;
            if (state_q == S_DECODE)
                ir_q <= bus.rom_q;
            if (set_illegal)
                illegal_q <= 1'b1;
            if (last)
                pc_q <= (opcode == OP_JMP) ? ir_q[7:0] : pc_q + 8'd1;
        end
    end

    // Strobes are decoded from the registered state and IR only.
    always_comb begin
        state_n     = state_q;
        cnt_n       = '0;
        last        = 1'b0;
        set_illegal = 1'b0;
        reg_we      = 1'b0;
        reg_sel     = 2'd0;
        acc_we      = 1'b0;
        dram_we     = 1'b0;
        led_we      = 1'b0;
        seg_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run || step_rise)
                    state_n = S_FETCH;
            end
            S_FETCH: begin
                if (cnt_q == 2'(ROM_LAT - 1))
                    state_n = S_DECODE;
                else
                    cnt_n = cnt_q + 2'd1;
            end
            S_DECODE: state_n = S_EXEC;
            S_EXEC: begin
                last = 1'b1;
                case (opcode)
                    OP_LI:    reg_we = 1'b1;
                    OP_LOAD: begin
                        last    = 1'b0;
                        state_n = S_MEM;
                    end
                    OP_STORE: dram_we = 1'b1;
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: acc_we = 1'b1;
                    OP_LIN: begin
                        reg_we  = 1'b1;
                        reg_sel = 2'd2;
                    end
                    OP_PRINT: led_we = 1'b1;
                    OP_SEG:   seg_we = 1'b1;
                    OP_ILL0, OP_ILL1: set_illegal = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                if (cnt_q == 2'(DRAM_LAT - 1))
                    state_n = S_WB;
                else
                    cnt_n = cnt_q + 2'd1;
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_sel = 2'd1;
                last    = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        if (last)
            state_n = run ? S_FETCH : S_IDLE;
    end

    assign bus.rom_addr   = pc_q;
    assign bus.pc         = pc_q;
    assign bus.state      = state_q;
    assign bus.reg_addr   = ir_q[11:8];
    assign bus.imm        = ir_q[7:0];
    assign bus.dram_addr  = ir_q[7:0];
    assign bus.alu_op     = ir_q[15:12];
    assign bus.reg_we     = reg_we;
    assign bus.reg_sel    = reg_sel;
    assign bus.acc_we     = acc_we;
    assign bus.dram_we    = dram_we;
    assign bus.led_we     = led_we;
    assign bus.seg_we     = seg_we;
    assign bus.instr_done = last;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer with default latencies (ROM_LAT=1,
//   DRAM_LAT=1) and a registered program ROM model (1-cycle read).
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        run;
    logic        step;
    logic [15:0] rom [256];
    int          n_cmp;
    int          n_err;

    cpu_sequencer_if bus ();

    cpu_sequencer #(.ROM_LAT(1), .DRAM_LAT(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .step (step),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

    // {reg_we, reg_sel[1:0], acc_we, dram_we, led_we, seg_we}
    logic [6:0] strobes;
    assign strobes = {bus.reg_we, bus.reg_sel, bus.acc_we, bus.dram_we, bus.led_we, bus.seg_we};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    // Assert reset for one edge, release 1 time unit after that edge.
    task automatic do_reset();
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
    endtask

    int done_cnt;
    int we_cnt;
    logic [15:0] prog [6];
    logic [6:0]  exp_strb [6];

    initial begin
        n_cmp = 0;
        n_err = 0;
        run   = 1'b1;
        step  = 1'b0;
        rst   = 1'b0;
        clear_rom();
        #2;

        // Reset state
        chk("rst_state", 16'(bus.state), 16'd0);
        chk("rst_pc", 16'(bus.pc), 16'd0);
        chk("rst_strobes", 16'(strobes), 16'd0);
        chk("rst_done", 16'(bus.instr_done), 16'd0);
        chk("rst_illegal", 16'(bus.illegal), 16'd0);

        // 1. LI r1,5
        rom[0] = 16'h1105;
        do_reset();
        tick(1);
        chk("li_fetch", 16'(bus.state), 16'd1);
        tick(1);
        chk("li_decode", 16'(bus.state), 16'd2);
        tick(1);
        chk("li_exec", 16'(bus.state), 16'd3);
        chk("li_strobes", 16'(strobes), 16'h40);
        chk("li_reg_addr", 16'(bus.reg_addr), 16'd1);
        chk("li_imm", 16'(bus.imm), 16'h05);
        chk("li_done", 16'(bus.instr_done), 16'd1);
        tick(1);
        chk("li_pc", 16'(bus.pc), 16'd1);
        chk("li_next_state", 16'(bus.state), 16'd1);
        chk("li_strobes_off", 16'(strobes), 16'd0);

        // 2. LOAD r2,[0x10]
        clear_rom();
        rom[0] = 16'h2210;
        do_reset();
        tick(3);
        chk("ld_exec_state", 16'(bus.state), 16'd3);
        chk("ld_exec_addr", 16'(bus.dram_addr), 16'h10);
        chk("ld_exec_strobes", 16'(strobes), 16'd0);
        chk("ld_exec_done", 16'(bus.instr_done), 16'd0);
        tick(1);
        chk("ld_mem_state", 16'(bus.state), 16'd4);
        chk("ld_mem_addr", 16'(bus.dram_addr), 16'h10);
        chk("ld_mem_strobes", 16'(strobes), 16'd0);
        tick(1);
        chk("ld_wb_state", 16'(bus.state), 16'd5);
        chk("ld_wb_addr", 16'(bus.dram_addr), 16'h10);
        chk("ld_wb_strobes", 16'(strobes), 16'h50);
        chk("ld_wb_reg_addr", 16'(bus.reg_addr), 16'd2);
        chk("ld_wb_done", 16'(bus.instr_done), 16'd1);
        chk("ld_wb_pc", 16'(bus.pc), 16'd0);
        tick(1);
        chk("ld_pc", 16'(bus.pc), 16'd1);
        chk("ld_after_strobes", 16'(strobes), 16'd0);

        // 3. JMP 0xFF then NOP at 0xFF wraps pc to 0
        clear_rom();
        rom[0] = 16'hD0FF;
        do_reset();
        tick(3);
        chk("jmp_strobes", 16'(strobes), 16'd0);
        chk("jmp_done", 16'(bus.instr_done), 16'd1);
        tick(1);
        chk("jmp_pc", 16'(bus.pc), 16'hFF);
        chk("jmp_rom_addr", 16'(bus.rom_addr), 16'hFF);
        tick(2);
        chk("nop_strobes", 16'(strobes), 16'd0);
        tick(1);
        chk("wrap_pc", 16'(bus.pc), 16'h00);

        // Opcode decode table in free-run: EXEC every 3rd edge
        clear_rom();
        prog[0] = 16'h3420; exp_strb[0] = 7'h04;  // STORE
        prog[1] = 16'h4100; exp_strb[1] = 7'h08;  // ADD
        prog[2] = 16'h9000; exp_strb[2] = 7'h08;  // NOT
        prog[3] = 16'hA500; exp_strb[3] = 7'h60;  // LIN
        prog[4] = 16'hB100; exp_strb[4] = 7'h02;  // PRINT
        prog[5] = 16'hC100; exp_strb[5] = 7'h01;  // PRINT7SEG
        for (int i = 0; i < 6; i++) rom[i] = prog[i];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(3);
            chk($sformatf("dec_strobes_%0d", i), 16'(strobes), 16'(exp_strb[i]));
            chk($sformatf("dec_alu_op_%0d", i), 16'(bus.alu_op), 16'(prog[i][15:12]));
            chk($sformatf("dec_done_%0d", i), 16'(bus.instr_done), 16'd1);
        end

        // 4. Single-step: step held high for 20 cycles
        clear_rom();
        rom[0] = 16'h1105;
        run = 1'b0;
        do_reset();
        step = 1'b1;
        done_cnt = 0;
        we_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.instr_done) done_cnt++;
            if (bus.reg_we) we_cnt++;
        end
        step = 1'b0;
        chk("step_done_count", 16'(done_cnt), 16'd1);
        chk("step_we_count", 16'(we_cnt), 16'd1);
        chk("step_state", 16'(bus.state), 16'd0);
        chk("step_pc", 16'(bus.pc), 16'd1);

        // 5. Illegal opcode, then LI r3,7
        clear_rom();
        rom[0] = 16'hE000;
        rom[1] = 16'h1307;
        run = 1'b1;
        do_reset();
        tick(3);
        chk("ill_strobes", 16'(strobes), 16'd0);
        tick(1);
        chk("ill_flag", 16'(bus.illegal), 16'd1);
        chk("ill_pc", 16'(bus.pc), 16'd1);
        tick(2);
        chk("ill_li_strobes", 16'(strobes), 16'h40);
        chk("ill_li_reg_addr", 16'(bus.reg_addr), 16'd3);
        chk("ill_li_imm", 16'(bus.imm), 16'h07);
        chk("ill_sticky", 16'(bus.illegal), 16'd1);

        // 6. Reset during MEM of a LOAD
        clear_rom();
        rom[0] = 16'h2210;
        do_reset();
        tick(4);
        chk("abort_in_mem", 16'(bus.state), 16'd4);
        rst = 1'b0;
        #1;
        chk("abort_state", 16'(bus.state), 16'd0);
        chk("abort_pc", 16'(bus.pc), 16'd0);
        chk("abort_illegal", 16'(bus.illegal), 16'd0);
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.reg_we) we_cnt++;
            tick(1);
        end
        chk("abort_we_count", 16'(we_cnt), 16'd0);
        rst = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
